// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the frame-buffer reader and writer.
// - Default image geometry and BRAM address width.
// - Frame-buffer size.
// - Read-controller state type.
// - A helper that gives the counter width for a given count.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int IMG_W     = 540;
    localparam int IMG_H     = 360;
    localparam int ADDR_W    = 18;
    localparam int FB_PIXELS = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        DONE      = 2'd2
    } rd_state_t;

    // A counter that runs from 0 to n-1 needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vga_fb_reader_if.sv
// ---------------------------------------------------------------------------
// vga_fb_reader_if
// BRAM read port between the frame-buffer reader and the frame-buffer BRAM.
//   bram_addr  : read address                       (master -> slave)
//   bram_rd    : read enable                        (master -> slave)
//   bram_dout  : read data, RD_LAT cycles after the address was sampled
//                                                   (slave -> master)
// ---------------------------------------------------------------------------
interface vga_fb_reader_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_rd;
    logic [7:0]        bram_dout;

    modport master (
        output bram_addr,
        output bram_rd,
        input  bram_dout
    );

    modport slave (
        input  bram_addr,
        input  bram_rd,
        output bram_dout
    );
endinterface

// File: rtl/vga_rd_lat_pipe.sv
// ---------------------------------------------------------------------------
// vga_rd_lat_pipe
// DEPTH-deep valid shift register that tracks BRAM reads in flight. A 1
// entering at vld_i in cycle n appears at vld_o in cycle n+DEPTH.
//   clk    : clock
//   rst_n  : asynchronous active-low reset, clears the pipe
//   vld_i  : read issued in this cycle
//   vld_o  : BRAM data for a read issued DEPTH cycles ago is on the bus
// ---------------------------------------------------------------------------
module vga_rd_lat_pipe #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o
);

    logic [DEPTH-1:0] pipe_q;

    generate
        if (DEPTH == 1) begin : g_single
            // Single stage: register the read strobe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= 1'b0;
                end else begin
                    pipe_q <= vld_i;
                end
            end
        end else begin : g_multi
            // Shift the read strobe towards the output by one stage each cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_q <= {DEPTH{1'b0}};
                end else begin
                    pipe_q <= {pipe_q[DEPTH-2:0], vld_i};
                end
            end
        end
    endgenerate

    assign vld_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/vga_fb_reader.sv
// ---------------------------------------------------------------------------
// vga_fb_reader
// Frame-buffer read controller in front of vga_port on clk_65.
//
// Function:
// - Turns the per-pixel bram_en strobe into sequential BRAM read addresses.
// - Aligns the returned BRAM data to the read latency.
// - Delivers an 8-bit grey pixel stream on rgb_o.
// - Restarts on every VSYNC active edge.
// - Ignores strobes once the image has been fully read.
//
// Ports:
//   clk_65       : pixel clock
//   rst_n        : asynchronous active-low reset
//   vga_vs_i     : VSYNC from vga_port
//   bram_en_i    : per-pixel read request from vga_port
//   bram_if      : BRAM read port (address, read enable, read data)
//   rgb_o        : fetched pixel, registered
//   rgb_vld_o    : rgb_o holds a fetched pixel
//   frame_err_o  : one-cycle pulse after a VSYNC edge that cut the previous
//                  frame short
// ---------------------------------------------------------------------------
module vga_fb_reader #(
    parameter int   IMG_W     = vga_pkg::IMG_W,
    parameter int   IMG_H     = vga_pkg::IMG_H,
    parameter int   ADDR_W    = vga_pkg::ADDR_W,
    parameter int   RD_LAT    = 2,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic                   clk_65,
    input  logic                   rst_n,
    input  logic                   vga_vs_i,
    input  logic                   bram_en_i,
    vga_fb_reader_if.master        bram_if,
    output logic [7:0]             rgb_o,
    output logic                   rgb_vld_o,
    output logic                   frame_err_o
);
    import vga_pkg::*;

    localparam int COL_W  = cnt_width(IMG_W);
    localparam int LINE_W = cnt_width(IMG_H);

    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(IMG_H - 1);

    // Frame-start detection
    logic vs_act_s;
    logic sof_s;
    logic vs_q;

    // Read-issue state
    rd_state_t         state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [COL_W-1:0]  col_q;
    logic [LINE_W-1:0] line_q;
    logic              rd_s;
    logic              last_s;

    // Data path
    logic              pipe_out_s;
    logic [7:0]        rgb_q;
    logic              rgb_vld_q;
    logic              frame_err_q;

    // VSYNC_POL=1 means active low, so the active level is the inverse of
    // the polarity bit.
    assign vs_act_s = (vga_vs_i == ~VSYNC_POL);
    assign sof_s    = vs_act_s & ~vs_q;

    // The read goes out in the same cycle as the strobe. A frame start wins
    // over a coincident strobe, so that strobe is dropped.
    assign rd_s   = bram_en_i & (state_q == ACTIVE) & ~sof_s;
    assign last_s = (col_q == COL_LAST) && (line_q == LINE_LAST);

    // Register VSYNC activity for edge detection.
    always_ff @(posedge clk_65 or negedge rst_n) begin
        if (!rst_n) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs_act_s;
        end
    end

    // Frame FSM with address, column and line counters.
    // The address stops at the last pixel, so it never leaves the image.
    always_ff @(posedge clk_65 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_SYNC;
            addr_q      <= {ADDR_W{1'b0}};
            col_q       <= {COL_W{1'b0}};
            line_q      <= {LINE_W{1'b0}};
            frame_err_q <= 1'b0;
        end else begin
            // A frame start while still ACTIVE means the last frame was short.
            frame_err_q <= sof_s & (state_q == ACTIVE);
            if (sof_s) begin
                state_q <= ACTIVE;
                addr_q  <= {ADDR_W{1'b0}};
                col_q   <= {COL_W{1'b0}};
                line_q  <= {LINE_W{1'b0}};
            end else begin
                case (state_q)
                    ACTIVE: begin
                        if (bram_en_i) begin
                            if (last_s) begin
                                state_q <= DONE;
                            end else begin
                                addr_q <= addr_q + ADDR_W'(1);
                            end
                            if (col_q == COL_LAST) begin
                                col_q <= {COL_W{1'b0}};
                                if (!last_s) begin
                                    line_q <= line_q + LINE_W'(1);
                                end
                            end else begin
                                col_q <= col_q + COL_W'(1);
                            end
                        end
                    end
                    WAIT_SYNC: begin
                        state_q <= WAIT_SYNC;
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= WAIT_SYNC;
                    end
                endcase
            end
        end
    end

    vga_rd_lat_pipe #(
        .DEPTH (RD_LAT)
    ) u_lat_pipe (
        .clk   (clk_65),
        .rst_n (rst_n),
        .vld_i (rd_s),
        .vld_o (pipe_out_s)
    );

    // Capture BRAM data when the matching read reaches the end of the
    // pipe. Otherwise drive black and mark the slot as invalid.
    always_ff @(posedge clk_65 or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q     <= 8'd0;
            rgb_vld_q <= 1'b0;
        end else if (pipe_out_s) begin
            rgb_q     <= bram_if.bram_dout;
            rgb_vld_q <= 1'b1;
        end else begin
            rgb_q     <= 8'd0;
            rgb_vld_q <= 1'b0;
        end
    end

    assign bram_if.bram_addr = addr_q;
    assign bram_if.bram_rd   = rd_s;
    assign rgb_o             = rgb_q;
    assign rgb_vld_o         = rgb_vld_q;
    assign frame_err_o       = frame_err_q;

endmodule
